// File: rtl/hm01b0_pkg.sv
// Shared types for the HM01B0 parallel-bus capture block.
// Pixel entry layout, FSM encoding and geometry defaults.
package hm01b0_pkg;

    localparam int WIDTH_DEF  = 320;
    localparam int HEIGHT_DEF = 240;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_FRAME  = 2'd2
    } state_t;

    typedef struct packed {
        logic           sof;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
        logic [7:0]     data;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

endpackage

// File: rtl/hm01b0_pix_fifo.sv
// Small synchronous FIFO for captured pixel entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hm01b0_pix_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hm01b0_capture.sv
// HM01B0 parallel camera receiver: oversampled pclk, x/y tagging,
// frame integrity flags and a buffered valid/ready pixel stream.
module hm01b0_capture
    import hm01b0_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           nreset,
    input  logic           cam_pclk,
    input  logic [7:0]     cam_data,
    input  logic           cam_vsync,
    input  logic           cam_hsync,
    output logic [7:0]     pix_data,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           pix_sof,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic           frame_start,
    output logic           frame_done,
    output logic           frame_ok,
    output logic           overflow
);

    localparam int IN_W = 11;
    localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT);

    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
    logic [IN_W-1:0]  sync_last;
    logic [SYNC_STAGES:0] prime;
    logic             primed;
    logic             pclk_s, vsync_s, hsync_s;
    logic [7:0]       data_s;
    logic             pclk_d, vsync_d, hsync_d;
    logic             pclk_rise, vsync_rise, vsync_fall, hsync_fall;

    state_t           state, state_n;
    logic             start, done, push_req, px_err, line_end;
    logic             drop, short_line, ok_n, err;
    logic [X_W-1:0]   x, x_inc;
    logic [Y_W-1:0]   y, y_inc, y_end;

    pix_t             entry, fifo_dout, last_q, shown;
    logic             fifo_full, fifo_empty, pop;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign pclk_s    = sync_last[10];
    assign vsync_s   = sync_last[9];
    assign hsync_s   = sync_last[8];
    assign data_s    = sync_last[7:0];
    assign primed    = prime[SYNC_STAGES];

    // The priming chain keeps the FSM from trusting reset zeros in the synchronizers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync_q  <= '0;
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
            hsync_d <= 1'b0;
            prime   <= '0;
        end else begin
            sync_q[0] <= {cam_pclk, cam_vsync, cam_hsync, cam_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            pclk_d  <= pclk_s;
            vsync_d <= vsync_s;
            hsync_d <= hsync_s;
            prime   <= {prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign pclk_rise  = pclk_s & ~pclk_d;
    assign vsync_rise = vsync_s & ~vsync_d;
    assign vsync_fall = ~vsync_s & vsync_d;
    assign hsync_fall = ~hsync_s & hsync_d;

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        done     = 1'b0;
        push_req = 1'b0;
        px_err   = 1'b0;
        line_end = 1'b0;
        unique case (state)
            S_SYNC: begin
                if (primed && !vsync_s) state_n = S_VBLANK;
            end
            S_VBLANK: begin
                if (vsync_rise) begin
                    start   = 1'b1;
                    state_n = S_FRAME;
                end
            end
            S_FRAME: begin
                if (pclk_rise && hsync_s) begin
                    if (x < X_MAX && y < Y_MAX) push_req = 1'b1;
                    else                        px_err   = 1'b1;
                end
                line_end = hsync_fall;
                if (vsync_fall) begin
                    done    = 1'b1;
                    state_n = S_VBLANK;
                end
            end
            default: state_n = S_SYNC;
        endcase
    end

    assign x_inc      = (x == '1) ? x : x + X_W'(1);
    assign y_inc      = (y == '1) ? y : y + Y_W'(1);
    assign y_end      = line_end ? y_inc : y;
    assign pop        = pix_valid & pix_ready;
    assign drop       = push_req & fifo_full & ~pop;
    assign short_line = line_end & (x < X_MAX);
    // A line closing in the same cycle as the frame is counted before judging it.
    assign ok_n = ~(err | px_err | short_line | drop | overflow | hsync_s)
                & (y_end == Y_MAX);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= S_SYNC;
        else         state <= state_n;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            x           <= '0;
            y           <= '0;
            err         <= 1'b0;
            overflow    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
        end else begin
            frame_start <= start;
            frame_done  <= done;
            if (start) begin
                x        <= '0;
                y        <= '0;
                err      <= 1'b0;
                overflow <= 1'b0;
                frame_ok <= 1'b0;
            end else begin
                if (line_end) begin
                    x <= '0;
                    y <= y_inc;
                end else if (push_req || px_err) begin
                    x <= x_inc;
                end
                err <= err | px_err | short_line | drop;
                if (drop) overflow <= 1'b1;
                if (done) frame_ok <= ok_n;
            end
        end
    end

    assign entry = '{sof: (x == '0 && y == '0), y: y, x: x, data: data_s};

    hm01b0_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clock (clock),
        .nreset(nreset),
        .push  (push_req),
        .din   (entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Last popped entry is held on the outputs while the FIFO is empty.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)  last_q <= '0;
        else if (pop) last_q <= fifo_dout;
    end

    assign shown     = fifo_empty ? last_q : fifo_dout;
    assign pix_valid = ~fifo_empty;
    assign pix_data  = shown.data;
    assign pix_x     = shown.x;
    assign pix_y     = shown.y;
    assign pix_sof   = shown.sof;

endmodule

// File: tb/tb_hm01b0_capture.sv
// Directed bench for hm01b0_capture on a reduced 24x4 frame geometry.
module tb_hm01b0_capture;
    import hm01b0_pkg::*;

    localparam int W  = 24;
    localparam int H  = 4;
    localparam int FD = 4;
    localparam int SS = 2;

    logic           clock = 1'b0;
    logic           nreset = 1'b0;
    logic           cam_pclk = 1'b0;
    logic [7:0]     cam_data = 8'h00;
    logic           cam_vsync = 1'b0;
    logic           cam_hsync = 1'b0;
    logic           pix_ready = 1'b1;
    logic [7:0]     pix_data;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           pix_sof, pix_valid;
    logic           frame_start, frame_done, frame_ok, overflow;

    hm01b0_capture #(
        .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD), .SYNC_STAGES(SS)
    ) dut (
        .clock(clock), .nreset(nreset),
        .cam_pclk(cam_pclk), .cam_data(cam_data),
        .cam_vsync(cam_vsync), .cam_hsync(cam_hsync),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_start(frame_start), .frame_done(frame_done),
        .frame_ok(frame_ok), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   nlines;
        int   mod_line;
        int   mod_len;
        int   rdy_x;
        int   endmode;
        int   exp_cnt;
        logic exp_ok;
        logic exp_ovf;
    } vec_t;

    vec_t vecs [10];
    int   compared = 0;
    int   mismatched = 0;
    pix_t rx_q [$];
    pix_t exp_q [$];
    int   start_cnt = 0;
    int   done_cnt = 0;
    logic last_ok = 1'b0;
    logic last_ovf = 1'b0;
    logic prev_ovf = 1'b0;

    always @(negedge clock) begin
        if (pix_valid && pix_ready)
            rx_q.push_back('{sof: pix_sof, y: pix_y, x: pix_x, data: pix_data});
        if (frame_start) start_cnt++;
        if (frame_done) begin
            done_cnt++;
            last_ok  = frame_ok;
            last_ovf = overflow;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // rdy: 1 drops pix_ready at the rise, 2 raises it two clocks after the rise
    task automatic cam_pix(input logic [7:0] d, input logic hs, input int rdy);
        cam_pclk  = 1'b0;
        cam_data  = d;
        cam_hsync = hs;
        ticks(4);
        cam_pclk = 1'b1;
        if (rdy == 1) pix_ready = 1'b0;
        if (rdy == 2) begin
            ticks(2);
            pix_ready = 1'b1;
            ticks(2);
        end else begin
            ticks(4);
        end
    endtask

    function automatic logic [7:0] dat(input int x, input int y);
        return 8'(x * 7 + y * 29 + 5);
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int s0, d0, n, len, rdy;
        bit last;
        check({tag, " ovf_hold"}, 32'(overflow), 32'(prev_ovf));
        exp_q.delete();
        rx_q.delete();
        for (int ln = 0; ln < v.nlines; ln++) begin
            len = (ln == v.mod_line) ? v.mod_len : W;
            for (int x = 0; x < len; x++) begin
                if (x < W && ln < H &&
                    !(v.rdy_x >= 0 && ln == 1 && x >= v.rdy_x + FD && x < v.rdy_x + 20))
                    exp_q.push_back('{sof: (x == 0 && ln == 0), y: 8'(ln),
                                      x: 9'(x), data: dat(x, ln)});
            end
        end
        s0 = start_cnt;
        d0 = done_cnt;
        cam_vsync = 1'b0;
        cam_pix(8'h00, 1'b0, 0);
        cam_pix(8'h00, 1'b0, 0);
        cam_vsync = 1'b1;
        cam_pix(8'h00, 1'b0, 0);
        cam_pix(8'h00, 1'b0, 0);
        for (int ln = 0; ln < v.nlines; ln++) begin
            len = (ln == v.mod_line) ? v.mod_len : W;
            for (int x = 0; x < len; x++) begin
                rdy = 0;
                if (v.rdy_x >= 0 && ln == 1) begin
                    if (x == v.rdy_x)      rdy = 1;
                    if (x == v.rdy_x + 20) rdy = 2;
                end
                cam_pix(dat(x, ln), 1'b1, rdy);
            end
            last = (ln == v.nlines - 1);
            if (last && v.endmode == 1) begin
                cam_pclk  = 1'b0;
                cam_hsync = 1'b0;
                cam_vsync = 1'b0;
                ticks(4);
            end else if (last && v.endmode == 2) begin
                cam_pclk  = 1'b0;
                cam_vsync = 1'b0;
                ticks(8);
                cam_hsync = 1'b0;
                ticks(4);
            end else begin
                cam_pix(8'h00, 1'b0, 0);
                cam_pix(8'h00, 1'b0, 0);
            end
        end
        cam_vsync = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        cam_pix(8'h00, 1'b0, 0);
        cam_pix(8'h00, 1'b0, 0);
        check({tag, " start_pulses"}, 32'(start_cnt - s0), 32'd1);
        check({tag, " pix_count"}, 32'(rx_q.size()), 32'(v.exp_cnt));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s pix%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
            if (rx_q[i] !== exp_q[i]) break;
        end
        check({tag, " frame_ok"}, 32'(last_ok), 32'(v.exp_ok));
        check({tag, " overflow"}, 32'(last_ovf), 32'(v.exp_ovf));
        prev_ovf = v.exp_ovf;
    endtask

    initial begin
        vecs[0] = '{4, -1,  0, -1, 0, 96, 1'b1, 1'b0};
        vecs[1] = '{4,  1, 18, -1, 0, 90, 1'b0, 1'b0};
        vecs[2] = '{4, -1,  0, -1, 0, 96, 1'b1, 1'b0};
        vecs[3] = '{4,  2, 30, -1, 0, 96, 1'b0, 1'b0};
        vecs[4] = '{4, -1,  0,  2, 0, 80, 1'b0, 1'b1};
        vecs[5] = '{4, -1,  0, -1, 0, 96, 1'b1, 1'b0};
        vecs[6] = '{5, -1,  0, -1, 0, 96, 1'b0, 1'b0};
        vecs[7] = '{3, -1,  0, -1, 0, 72, 1'b0, 1'b0};
        vecs[8] = '{4,  3, 10, -1, 2, 82, 1'b0, 1'b0};
        vecs[9] = '{4, -1,  0, -1, 1, 96, 1'b1, 1'b0};

        ticks(3);
        check("rst valid", 32'(pix_valid), 32'd0);
        check("rst pix", 32'({pix_sof, pix_y, pix_x, pix_data}), 32'd0);
        check("rst flags", 32'({frame_start, frame_done, frame_ok, overflow}), 32'd0);

        cam_vsync = 1'b1;
        ticks(2);
        nreset = 1'b1;
        ticks(2);
        for (int ln = 0; ln < 2; ln++) begin
            for (int x = 0; x < 10; x++) cam_pix(dat(x, ln), 1'b1, 0);
            cam_pix(8'h00, 1'b0, 0);
            cam_pix(8'h00, 1'b0, 0);
        end
        check("midframe pixels", 32'(rx_q.size()), 32'd0);
        check("midframe start", 32'(start_cnt), 32'd0);
        cam_vsync = 1'b0;
        repeat (3) cam_pix(8'h00, 1'b0, 0);
        check("midframe done", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        cam_vsync = 1'b0;
        cam_pix(8'h00, 1'b0, 0);
        cam_pix(8'h00, 1'b0, 0);
        cam_vsync = 1'b1;
        cam_pix(8'h00, 1'b0, 0);
        cam_pix(8'h00, 1'b0, 0);
        pix_ready = 1'b0;
        for (int x = 0; x < 6; x++) cam_pix(dat(x, 0), 1'b1, 0);
        check("prerst valid", 32'(pix_valid), 32'd1);
        check("prerst overflow", 32'(overflow), 32'd1);
        cam_pclk = 1'b0;
        ticks(2);
        #2;
        nreset = 1'b0;
        #1;
        check("async valid", 32'(pix_valid), 32'd0);
        check("async pix", 32'({pix_sof, pix_y, pix_x, pix_data}), 32'd0);
        check("async flags", 32'({frame_start, frame_done, frame_ok, overflow}), 32'd0);
        cam_vsync = 1'b0;
        cam_hsync = 1'b0;
        pix_ready = 1'b1;
        ticks(3);
        nreset = 1'b1;
        ticks(2);
        prev_ovf = 1'b0;
        run_frame(vecs[0], "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
